// File: rtl/fb_pattern_writer.sv
//------------------------------------------------------------------------------
// fb_pattern_writer : Avalon-MM write master filling one HDISP x VDISP frame
//                     buffer with a selectable test pattern per start pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fb_pattern_writer #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          GRID      = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [1:0]  pattern,
    input  logic [23:0] solid_rgb,
    output logic        busy,
    output logic        done,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int          BAR_W     = (HDISP / 8 > 0) ? HDISP / 8 : 1;
    localparam logic [15:0] X_LAST    = 16'(HDISP - 1);
    localparam logic [15:0] Y_LAST    = 16'(VDISP - 1);
    localparam logic [15:0] BAR_LAST  = 16'(BAR_W - 1);
    localparam logic [15:0] GRID_MASK = 16'(GRID - 1);

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [2:0]  bar_q, bar_d;
    logic [15:0] bar_cnt_q, bar_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [23:0] data_q, data_d;
    logic [1:0]  pat_q, pat_d;
    logic [23:0] rgb_q, rgb_d;

    logic        accept;
    logic        last_pix;
    logic [15:0] x_nxt;
    logic [15:0] y_nxt;
    logic [2:0]  bar_nxt;
    logic [15:0] bar_cnt_nxt;

    function automatic logic [23:0] pixel(
        input logic [1:0]  pat,
        input logic [23:0] rgb,
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [2:0]  bar
    );
        logic [23:0] c;
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0:    c = 24'hFFFFFF;
                    3'd1:    c = 24'hFFFF00;
                    3'd2:    c = 24'h00FFFF;
                    3'd3:    c = 24'h00FF00;
                    3'd4:    c = 24'hFF00FF;
                    3'd5:    c = 24'hFF0000;
                    3'd6:    c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            2'd1:    c = (((x & GRID_MASK) == 16'd0) || ((y & GRID_MASK) == 16'd0)) ?
                         24'hFFFFFF : 24'h000000;
            2'd2:    c = {x[7:0], y[7:0], x[7:0] ^ y[7:0]};
            default: c = rgb;
        endcase
        return c;
    endfunction

    // Raster advance; the bar index follows a per-line counter instead of x/BAR_W.
    always_comb begin
        x_nxt       = x_q + 16'd1;
        y_nxt       = y_q;
        bar_nxt     = bar_q;
        bar_cnt_nxt = bar_cnt_q + 16'd1;
        if (x_q == X_LAST) begin
            x_nxt       = 16'd0;
            y_nxt       = y_q + 16'd1;
            bar_nxt     = 3'd0;
            bar_cnt_nxt = 16'd0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_nxt = 16'd0;
            bar_nxt     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        pat_d     = pat_q;
        rgb_d     = rgb_q;
        accept    = (state_q == S_WRITE) && !avm_waitrequest;
        last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d     = pattern;
                    rgb_d     = solid_rgb;
                    x_d       = 16'd0;
                    y_d       = 16'd0;
                    bar_d     = 3'd0;
                    bar_cnt_d = 16'd0;
                    addr_d    = BASE_ADDR;
                    data_d    = pixel(pattern, solid_rgb, 16'd0, 16'd0, 3'd0);
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    addr_d = addr_q + 32'd4;
                    if (last_pix) begin
                        state_d = S_DONE;
                    end else begin
                        x_d       = x_nxt;
                        y_d       = y_nxt;
                        bar_d     = bar_nxt;
                        bar_cnt_d = bar_cnt_nxt;
                        data_d    = pixel(pat_q, rgb_q, x_nxt, y_nxt, bar_nxt);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= 16'd0;
            y_q       <= 16'd0;
            bar_q     <= 3'd0;
            bar_cnt_q <= 16'd0;
            addr_q    <= BASE_ADDR;
            data_q    <= 24'd0;
            pat_q     <= 2'd0;
            rgb_q     <= 24'd0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_q     <= bar_d;
            bar_cnt_q <= bar_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pat_q     <= pat_d;
            rgb_q     <= rgb_d;
        end
    end

    // Outputs decode straight from the state flop so reset drops avm_write at once.
    assign avm_write      = (state_q == S_WRITE);
    assign busy           = (state_q == S_WRITE);
    assign done           = (state_q == S_DONE);
    assign avm_address    = addr_q;
    assign avm_writedata  = {8'h00, data_q};
    assign avm_byteenable = 4'hF;

endmodule

`default_nettype wire

// File: tb/tb_fb_pattern_writer.sv
//------------------------------------------------------------------------------
// tb_fb_pattern_writer : randomized bench with a frame-level reference model
//                        for two pattern-writer instances of different geometry.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fb_pattern_writer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start   [2];
    logic        wreq    [2];
    logic [1:0]  pattern [2];
    logic [23:0] rgb     [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        write_w [2];
    logic [31:0] addr_w  [2];
    logic [31:0] data_w  [2];
    logic [3:0]  be_w    [2];

    always #5 sys_clk = ~sys_clk;

    fb_pattern_writer #(.HDISP(16), .VDISP(4), .BASE_ADDR(32'h0000_0000), .GRID(4)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start[0]), .pattern(pattern[0]),
        .solid_rgb(rgb[0]), .busy(busy_w[0]), .done(done_w[0]), .avm_address(addr_w[0]),
        .avm_write(write_w[0]), .avm_writedata(data_w[0]), .avm_byteenable(be_w[0]),
        .avm_waitrequest(wreq[0])
    );

    fb_pattern_writer #(.HDISP(8), .VDISP(8), .BASE_ADDR(32'h0000_0400), .GRID(4)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start[1]), .pattern(pattern[1]),
        .solid_rgb(rgb[1]), .busy(busy_w[1]), .done(done_w[1]), .avm_address(addr_w[1]),
        .avm_write(write_w[1]), .avm_writedata(data_w[1]), .avm_byteenable(be_w[1]),
        .avm_waitrequest(wreq[1])
    );

    function automatic int hd(int k);   return (k == 0) ? 16 : 8;            endfunction
    function automatic int vd(int k);   return (k == 0) ? 4 : 8;             endfunction
    function automatic int gr(int k);   return 4;                            endfunction
    function automatic logic [31:0] base(int k); return (k == 0) ? 32'h0 : 32'h400; endfunction

    // Reference pixel colour straight from the pattern definitions.
    function automatic logic [23:0] pix(int pat, logic [23:0] c, int x, int y, int h, int g);
        int          b;
        logic [7:0]  xb, yb;
        logic [23:0] r;
        xb = x[7:0];
        yb = y[7:0];
        case (pat)
            0: begin
                b = x / (h / 8);
                if (b > 7) b = 7;
                case (b)
                    0: r = 24'hFFFFFF;  1: r = 24'hFFFF00;
                    2: r = 24'h00FFFF;  3: r = 24'h00FF00;
                    4: r = 24'hFF00FF;  5: r = 24'hFF0000;
                    6: r = 24'h0000FF;  default: r = 24'h000000;
                endcase
            end
            1:       r = ((x % g == 0) || (y % g == 0)) ? 24'hFFFFFF : 24'h000000;
            2:       r = {xb, yb, xb ^ yb};
            default: r = c;
        endcase
        return r;
    endfunction

    int          checks = 0;
    int          errors = 0;
    bit          m_write  [2];
    bit          m_done   [2];
    int          idx      [2];
    int          m_pat    [2];
    logic [23:0] m_rgb    [2];
    int          fidx     [2];
    int          dut_acc  [2];
    int          done_seen[2];
    logic [31:0] cap      [2][64];
    int          stall_pct[2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare at the falling edge, then advance the model to the next rising edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_write[k] = 0; m_done[k] = 0; idx[k] = 0; fidx[k] = 0;
            dut_acc[k] = 0; done_seen[k] = 0; m_pat[k] = 0; m_rgb[k] = 24'd0;
        end
        forever begin
            @(negedge sys_clk);
            for (int k = 0; k < 2; k++) begin
                if (!sys_rst_n) begin
                    chk("rst_write", 32'(write_w[k]), 32'd0);
                    chk("rst_busy",  32'(busy_w[k]),  32'd0);
                    chk("rst_done",  32'(done_w[k]),  32'd0);
                    chk("rst_addr",  addr_w[k],       base(k));
                    chk("rst_data",  data_w[k],       32'd0);
                    chk("rst_be",    32'(be_w[k]),    32'hF);
                    m_write[k] = 0; m_done[k] = 0; idx[k] = 0; fidx[k] = 0;
                end else begin
                    chk("write", 32'(write_w[k]), 32'(m_write[k]));
                    chk("busy",  32'(busy_w[k]),  32'(m_write[k]));
                    chk("done",  32'(done_w[k]),  32'(m_done[k]));
                    chk("be",    32'(be_w[k]),    32'hF);
                    if (m_write[k]) begin
                        chk("addr", addr_w[k], base(k) + 32'(4 * idx[k]));
                        chk("data", data_w[k], {8'h00, pix(m_pat[k], m_rgb[k], idx[k] % hd(k),
                                                           idx[k] / hd(k), hd(k), gr(k))});
                    end
                    if (done_w[k]) done_seen[k]++;
                    if (write_w[k] && !wreq[k]) begin
                        if (fidx[k] < 64) cap[k][fidx[k]] = data_w[k];
                        fidx[k]++;
                        dut_acc[k]++;
                    end
                    if (m_done[k]) begin
                        m_done[k] = 0;
                    end else if (m_write[k]) begin
                        if (!wreq[k]) begin
                            idx[k]++;
                            if (idx[k] == hd(k) * vd(k)) begin
                                m_write[k] = 0;
                                m_done[k]  = 1;
                            end
                        end
                    end else if (start[k]) begin
                        m_pat[k]   = int'(pattern[k]);
                        m_rgb[k]   = rgb[k];
                        idx[k]     = 0;
                        fidx[k]    = 0;
                        m_write[k] = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        for (int k = 0; k < 2; k++)
            wreq[k] = (stall_pct[k] > 0) && ($urandom_range(99, 0) < stall_pct[k]);
    endtask

    task automatic pulse_start(int k, int pat, logic [23:0] c);
        pattern[k] = pat[1:0];
        rgb[k]     = c;
        start[k]   = 1'b1;
        tick();
        start[k]   = 1'b0;
    endtask

    task automatic wait_done(int k, int budget, string name);
        int d0 = done_seen[k];
        int n  = 0;
        while (done_seen[k] == d0 && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk(name, 32'(done_seen[k] - d0), 32'd1);
    endtask

    int a0;
    int n;

    initial begin
        sys_rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; wreq[k] = 1'b0; pattern[k] = 2'd0; rgb[k] = 24'd0;
            stall_pct[k] = 0;
        end
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (2) tick();

        // Colour bars, no stalls
        a0 = dut_acc[0];
        pulse_start(0, 0, 24'd0);
        wait_done(0, 200, "t2_done_once");
        chk("t2_writes", 32'(dut_acc[0] - a0), 32'd64);
        chk("t2_w00",    cap[0][0],  32'h00FFFFFF);
        chk("t2_w20",    cap[0][2],  32'h00FFFF00);
        chk("t2_w80",    cap[0][8],  32'h00FF00FF);
        chk("t2_w15_3",  cap[0][63], 32'h00000000);

        // Same frame with 50% waitrequest
        stall_pct[0] = 50;
        a0 = dut_acc[0];
        pulse_start(0, 0, 24'd0);
        wait_done(0, 1000, "t3_done_once");
        chk("t3_writes", 32'(dut_acc[0] - a0), 32'd64);
        stall_pct[0] = 0;

        // Mid-frame start and pattern changes are ignored
        stall_pct[0] = 25;
        pulse_start(0, 2, 24'd0);
        repeat (10) tick();
        pulse_start(0, 3, 24'hABCDEF);
        pattern[0] = 2'd1;
        repeat (5) tick();
        wait_done(0, 800, "t4_done_once");
        stall_pct[0] = 0;
        pulse_start(0, 2, 24'd0);
        chk("t4_restart_addr", addr_w[0], 32'h0);
        wait_done(0, 200, "t4b_done_once");

        // Reset mid-frame after 20 writes
        a0 = dut_acc[0];
        pulse_start(0, 1, 24'd0);
        n = 0;
        while (dut_acc[0] - a0 < 20 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reached20", 32'(dut_acc[0] - a0 >= 20), 32'd1);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("t5_async_drop", 32'(write_w[0]), 32'd0);
        chk("t5_async_busy", 32'(busy_w[0]),  32'd0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        pulse_start(0, 3, 24'h123456);
        chk("t5_first_addr", addr_w[0], 32'h0);
        chk("t5_first_data", data_w[0], 32'h00123456);
        wait_done(0, 200, "t5_done_once");

        // Grid and solid on the 8x8 instance
        pulse_start(1, 1, 24'd0);
        wait_done(1, 200, "t6_done_once");
        chk("t6_grid_0_3", cap[1][24], 32'h00FFFFFF);
        chk("t6_grid_5_5", cap[1][45], 32'h00000000);
        chk("t6_grid_4_1", cap[1][12], 32'h00FFFFFF);
        stall_pct[1] = 30;
        pulse_start(1, 3, 24'h123456);
        wait_done(1, 600, "t6b_done_once");
        chk("t6_solid_37", cap[1][37], 32'h00123456);
        stall_pct[1] = 0;

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
